// File: rtl/alu_cmd_seq.sv
// Command sequencer for the ALU math stage: serializes one opcode/operand command
// onto the ALU byte bus, waits for the ALU done pulse and returns a response.
module alu_cmd_seq #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        ctl,
  output logic [7:0]  dat,
  input  logic [31:0] alu_result,
  input  logic        alu_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_op,
  output logic        rsp_err
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned OPND_W = 16;
  localparam int unsigned RES_W  = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [OP_W-1:0] OP_LAST_LEGAL = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_OP,
    ST_SEND_AM,
    ST_SEND_AL,
    ST_SEND_BM,
    ST_SEND_BL,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OP_W-1:0]     r_op;
  logic [OPND_W-1:0]   r_a;
  logic [OPND_W-1:0]   r_b;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ctl;
  logic [BYTE_W-1:0]   r_dat;
  logic                r_rsp_valid;
  logic [RES_W-1:0]    r_rsp_result;
  logic [OP_W-1:0]     r_rsp_op;
  logic                r_rsp_err;

  logic                w_accept;
  logic                w_need_a;
  logic                w_need_b;
  logic                w_timeout;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_ctl_nxt;
  logic [BYTE_W-1:0]   w_dat_nxt;
  logic                w_rsp_valid_nxt;
  logic [RES_W-1:0]    w_rsp_result_nxt;
  logic [OP_W-1:0]     w_rsp_op_nxt;
  logic                w_rsp_err_nxt;

  assign cmd_ready  = (r_state == ST_IDLE) && !rst;
  assign w_accept   = cmd_valid && cmd_ready;
  // Operand usage per opcode: A for ADD..INC_A and ACCUM, B for ADD..DIV_B_A and INC_B.
  assign w_need_a   = (r_op <= 4'd6) || (r_op == 4'd9);
  assign w_need_b   = (r_op <= 4'd5) || (r_op == 4'd7);
  assign w_timeout  = (r_state == ST_WAIT) && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_cnt_nxt  = (r_state == ST_WAIT) ? r_cnt + 1'b1 : '0;

  assign ctl        = r_ctl;
  assign dat        = r_dat;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_op     = r_rsp_op;
  assign rsp_err    = r_rsp_err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (cmd_op <= OP_LAST_LEGAL) ? ST_SEND_OP : ST_RESP;
        end
      end
      ST_SEND_OP: begin
        if (w_need_a) begin
          w_state_nxt = ST_SEND_AM;
        end else if (w_need_b) begin
          w_state_nxt = ST_SEND_BM;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_SEND_AM: w_state_nxt = ST_SEND_AL;
      ST_SEND_AL: w_state_nxt = w_need_b ? ST_SEND_BM : ST_WAIT;
      ST_SEND_BM: w_state_nxt = ST_SEND_BL;
      ST_SEND_BL: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (alu_ready || w_timeout) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: values the output registers take on the coming edge
  always_comb begin
    w_ctl_nxt        = (w_state_nxt == ST_SEND_OP);
    w_dat_nxt        = '0;
    w_rsp_valid_nxt  = (w_state_nxt == ST_RESP);
    w_rsp_result_nxt = r_rsp_result;
    w_rsp_op_nxt     = r_rsp_op;
    w_rsp_err_nxt    = r_rsp_err;
    case (w_state_nxt)
      ST_SEND_OP: w_dat_nxt = {4'h0, cmd_op};
      ST_SEND_AM: w_dat_nxt = r_a[15:8];
      ST_SEND_AL: w_dat_nxt = r_a[7:0];
      ST_SEND_BM: w_dat_nxt = r_b[15:8];
      ST_SEND_BL: w_dat_nxt = r_b[7:0];
      default:    w_dat_nxt = '0;
    endcase
    if (r_state == ST_IDLE && w_state_nxt == ST_RESP) begin
      w_rsp_result_nxt = '0;
      w_rsp_op_nxt     = cmd_op;
      w_rsp_err_nxt    = 1'b1;
    end else if (r_state == ST_WAIT && w_state_nxt == ST_RESP) begin
      // A done pulse on the last allowed cycle still counts as success.
      w_rsp_result_nxt = alu_ready ? alu_result : '0;
      w_rsp_op_nxt     = r_op;
      w_rsp_err_nxt    = !alu_ready;
    end
  end

  // Output, counter and command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_ctl        <= 1'b0;
      r_dat        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_op     <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= cmd_op;
        r_a  <= cmd_a;
        r_b  <= cmd_b;
      end
      r_cnt        <= w_cnt_nxt;
      r_ctl        <= w_ctl_nxt;
      r_dat        <= w_dat_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_result <= w_rsp_result_nxt;
      r_rsp_op     <= w_rsp_op_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
    end
  end

endmodule
